// File: rtl/disp_pkg.sv
// Shared display definitions: character codes and the scroller state encoding.
package disp_pkg;

    localparam logic [3:0] CH_MINUS = 4'd10;
    localparam logic [3:0] CH_F     = 4'd11;
    localparam logic [3:0] CH_BLANK = 4'd12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/msg_scroller_tick_gen.sv
// Scroll-step prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls a buffered message, padded with four blanks, through a 4-character window.
module msg_scroller
    import disp_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic [$clog2(MAX_LEN):0]   len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       wrap,
    output logic                       done,
    output logic [3:0]                 char3,
    output logic [3:0]                 char2,
    output logic [3:0]                 char1,
    output logic [3:0]                 char0
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(MAX_LEN + 4);

    state_e            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [LW-1:0]     len_q, len_d;
    logic              loop_q, loop_d;
    logic              busy_q, busy_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic [3:0][3:0]   char_q, char_d;
    logic [3:0]        buf_q [MAX_LEN];
    logic [3:0]        buf_d [MAX_LEN];

    logic              tick, tick_clr, start_ok;
    logic [PW:0]       period, idx;
    logic [3:0][3:0]   win;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign start_ok = start && (len != '0) && (len <= LW'(MAX_LEN));
    assign period   = (PW+1)'(len_q) + (PW+1)'(4);

    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        len_d    = len_q;
        loop_d   = loop_q;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        tick_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Prescaler held at zero so the first step lands TICK_DIV cycles after start.
                tick_clr = 1'b1;
                if (start_ok) begin
                    state_d = RUN;
                    pos_d   = '0;
                    len_d   = len;
                    loop_d  = loop;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    pos_d    = '0;
                    done_d   = 1'b1;
                    tick_clr = 1'b1;
                end else if (start_ok) begin
                    pos_d    = '0;
                    len_d    = len;
                    loop_d   = loop;
                    tick_clr = 1'b1;
                end else if (tick) begin
                    if ((PW+1)'(pos_q) == period - (PW+1)'(1)) begin
                        pos_d = '0;
                        if (loop_q) begin
                            wrap_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // win[3] is the leftmost digit (stream index pos).
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = (PW+1)'(pos_q) + (PW+1)'(k);
            if (idx >= period) begin
                idx = idx - period;
            end
            if (idx < (PW+1)'(len_q)) begin
                win[3-k] = buf_q[idx[AW-1:0]];
            end else begin
                win[3-k] = CH_BLANK;
            end
        end
        char_d = (state_q == RUN) ? win : {4{CH_BLANK}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            char_q  <= {4{CH_BLANK}};
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= CH_BLANK;
            end
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            char_q  <= char_d;
            buf_q   <= buf_d;
        end
    end

    assign busy  = busy_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign char3 = char_q[3];
    assign char2 = char_q[2];
    assign char1 = char_q[1];
    assign char0 = char_q[0];

endmodule

// File: tb/tb_msg_scroller.sv
// Randomised bench for msg_scroller against a cycles-since-start reference model.
module tb_msg_scroller;

    localparam int TD = 4;
    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [4:0] len = '0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy, wrap, done;
    logic [3:0] char3, char2, char1, char0;

    msg_scroller #(
        .TICK_DIV (TD),
        .MAX_LEN  (ML)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .loop    (loop),
        .start   (start),
        .stop    (stop),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done),
        .char3   (char3),
        .char2   (char2),
        .char1   (char1),
        .char0   (char0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: running flag, latched length/loop, cycles since start, buffer.
    bit         m_run;
    int         m_len;
    bit         m_loop;
    int         m_cyc;
    logic [3:0] m_buf [ML];
    logic [15:0] exp_chars;
    bit          exp_wrap, exp_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_window();
        logic [15:0] w = 16'hCCCC;
        int p, per, i;
        if (m_run) begin
            per = m_len + 4;
            p   = m_loop ? (m_cyc / TD) % per : m_cyc / TD;
            for (int k = 0; k < 4; k++) begin
                i = (p + k) % per;
                w = {w[11:0], (i < m_len) ? m_buf[i] : 4'd12};
            end
        end
        return w;
    endfunction

    function automatic logic [15:0] dut_chars();
        return {char3, char2, char1, char0};
    endfunction

    task automatic check_outputs();
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("wrap", 32'(wrap), 32'(exp_wrap));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("chars", 32'(dut_chars()), 32'(exp_chars));
    endtask

    // Advance one clock with the inputs currently driven, then compare.
    task automatic cycle();
        bit sv;
        sv = start && (len >= 1) && (len <= ML);
        exp_chars = model_window();
        exp_wrap  = 1'b0;
        exp_done  = 1'b0;
        if (m_run) begin
            if (stop) begin
                m_run    = 1'b0;
                exp_done = 1'b1;
            end else if (sv) begin
                m_len  = int'(len);
                m_loop = loop;
                m_cyc  = 0;
            end else begin
                m_cyc++;
                if (m_cyc % TD == 0 && (m_cyc / TD) % (m_len + 4) == 0) begin
                    if (m_loop) begin
                        exp_wrap = 1'b1;
                    end else begin
                        m_run    = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end
        end else if (sv) begin
            m_run  = 1'b1;
            m_len  = int'(len);
            m_loop = loop;
            m_cyc  = 0;
        end
        if (wr_en) m_buf[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic go(input int l, input bit lp);
        start = 1'b1; len = 5'(l); loop = lp;
        cycle();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_len = 0; m_loop = 1'b0; m_cyc = 0;
        for (int i = 0; i < ML; i++) m_buf[i] = 4'd12;
        exp_chars = 16'hCCCC; exp_wrap = 1'b0; exp_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a run clears state and the buffer.
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        go(4, 1'b0);
        idle(6);
        do_reset();
        go(16, 1'b1);
        idle(3);
        check_eq("post_reset_buf", 32'(dut_chars()), 32'h0000CCCC);
        halt();
        idle(2);

        // One-shot pass of "-194".
        wr(0, 10); wr(1, 1); wr(2, 9); wr(3, 4);
        go(4, 1'b0);
        idle(1);
        check_eq("oneshot_first", 32'(dut_chars()), 32'h0000A194);
        idle(4);
        check_eq("oneshot_step1", 32'(dut_chars()), 32'h0000194C);
        idle(40);
        check_eq("oneshot_idle", 32'(busy), 32'd0);

        // Continuous loop with a 2-character message.
        wr(0, 1); wr(1, 0);
        go(2, 1'b1);
        idle(60);

        // Stop beats a simultaneous start; zero length is ignored.
        go(4, 1'b1);
        idle(5);
        start = 1'b1; stop = 1'b1; len = 5'd4;
        cycle();
        idle(2);
        go(0, 1'b0);
        idle(2);
        check_eq("len0_ignored", 32'(busy), 32'd0);

        // Live write into the visible window.
        go(4, 1'b0);
        idle(1);
        wr(2, 11);
        idle(1);
        check_eq("live_write", 32'(char1), 32'd11);

        // Restart at pos 3 realigns the prescaler.
        idle(9);
        go(4, 1'b0);
        idle(30);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom);
            wr_data = 4'($urandom);
            start   = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            len     = 5'($urandom_range(0, 20));
            loop    = 1'($urandom);
            cycle();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
